// File: rtl/data_mem_responder.sv
// Data-memory responder for the multicycle core: address register, word RAM,
// single-word accesses with an optional wait-state count, and status flags.
module data_mem_responder #(
   parameter int DW          = 16,
   parameter int AW          = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] addr_in,
   input  logic          addr_l,
   input  logic          mem_en,
   input  logic          mem_wr,
   input  logic [DW-1:0] wdata,
   input  logic          mem_e,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          done,
   output logic          rdata_valid,
   output logic          err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [3:0]  CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);

   state_t        state, state_nxt;
   logic [AW-1:0] addr_reg;
   logic [DW-1:0] rdata_reg;
   logic [DW-1:0] wdata_reg;
   logic          op_reg;
   logic [3:0]    cnt;
   logic          rdata_valid_reg;
   logic          err_reg;
   logic [DW-1:0] mem [DEPTH];

   logic          accept;
   logic          perform;
   logic          acc_wr;
   logic          in_range;
   logic [AW-1:0] acc_addr;
   logic [DW-1:0] acc_wdata;

   // Without wait states the access happens at the accept edge, so the live
   // inputs are used; otherwise the captured request is replayed from WAIT.
   always_comb begin
      accept    = mem_en && (state != S_WAIT);
      perform   = 1'b0;
      acc_addr  = addr_reg;
      acc_wr    = op_reg;
      acc_wdata = wdata_reg;
      if (state == S_WAIT) begin
         perform = (cnt == 4'd0);
      end else if (NO_WAIT && mem_en) begin
         perform   = 1'b1;
         acc_addr  = addr_l ? addr_in : addr_reg;
         acc_wr    = mem_wr;
         acc_wdata = wdata;
      end
      in_range = ({1'b0, acc_addr} < DEPTH_W);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_WAIT: begin
            if (cnt == 4'd0) state_nxt = S_DONE;
         end
         default: begin
            if (mem_en) state_nxt = NO_WAIT ? S_DONE : S_WAIT;
            else        state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         addr_reg        <= '0;
         rdata_reg       <= '0;
         wdata_reg       <= '0;
         op_reg          <= 1'b0;
         cnt             <= '0;
         rdata_valid_reg <= 1'b0;
         err_reg         <= 1'b0;
      end else begin
         state <= state_nxt;
         if (addr_l && state != S_WAIT) begin
            addr_reg <= addr_in;
            err_reg  <= 1'b0;
         end
         if (accept) begin
            op_reg    <= mem_wr;
            wdata_reg <= wdata;
            cnt       <= CNT_INIT;
         end
         if (state == S_WAIT) begin
            if (cnt != 4'd0) cnt <= cnt - 4'd1;
            if (mem_en) err_reg <= 1'b1;
         end
         // Error updates are placed last so they win over an address-latch clear.
         if (perform) begin
            if (!in_range) begin
               rdata_reg       <= '0;
               rdata_valid_reg <= 1'b0;
               err_reg         <= 1'b1;
            end else if (acc_wr) begin
               rdata_valid_reg <= 1'b0;
            end else begin
               rdata_reg       <= mem[acc_addr];
               rdata_valid_reg <= 1'b1;
            end
         end
      end
   end

   // RAM has no reset; gating on reset_n keeps an aborted write out of storage.
   always_ff @(posedge clk) begin
      if (reset_n && perform && acc_wr && in_range) mem[acc_addr] <= acc_wdata;
   end

   assign rdata       = mem_e ? rdata_reg : '0;
   assign busy        = (state == S_WAIT);
   assign done        = (state == S_DONE);
   assign rdata_valid = rdata_valid_reg;
   assign err         = err_reg;

endmodule
